// File: rtl/cache_req_arbiter_if.sv
// cache_req_arbiter_if: requester, cache and monitor signals of the CPU/GPU cache request arbiter.
interface cache_req_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  cpu_req_valid;
    logic                  cpu_req_ready;
    logic [ADDR_WIDTH-1:0] cpu_req_addr;
    logic [31:0]           cpu_req_wdata;
    logic                  cpu_req_we;
    logic                  cpu_resp_valid;
    logic [31:0]           cpu_resp_rdata;
    logic                  cpu_resp_err;
    logic                  gpu_req_valid;
    logic                  gpu_req_ready;
    logic [ADDR_WIDTH-1:0] gpu_req_addr;
    logic [31:0]           gpu_req_wdata;
    logic                  gpu_req_we;
    logic                  gpu_resp_valid;
    logic [31:0]           gpu_resp_rdata;
    logic                  gpu_resp_err;
    logic                  cache_req_valid;
    logic                  cache_req_ready;
    logic [ADDR_WIDTH-1:0] cache_req_addr;
    logic [31:0]           cache_req_wdata;
    logic                  cache_req_we;
    logic                  cache_req_is_gpu;
    logic [31:0]           cache_req_rdata;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  cpu_grant_cnt;
    logic [CNT_WIDTH-1:0]  gpu_grant_cnt;

    modport slave (
        input  cpu_req_valid, cpu_req_addr, cpu_req_wdata, cpu_req_we,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_err,
        input  gpu_req_valid, gpu_req_addr, gpu_req_wdata, gpu_req_we,
        output gpu_req_ready, gpu_resp_valid, gpu_resp_rdata, gpu_resp_err,
        output cache_req_valid, cache_req_addr, cache_req_wdata, cache_req_we, cache_req_is_gpu,
        input  cache_req_ready, cache_req_rdata,
        output busy, cpu_grant_cnt, gpu_grant_cnt
    );

    modport master (
        output cpu_req_valid, cpu_req_addr, cpu_req_wdata, cpu_req_we,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_err,
        output gpu_req_valid, gpu_req_addr, gpu_req_wdata, gpu_req_we,
        input  gpu_req_ready, gpu_resp_valid, gpu_resp_rdata, gpu_resp_err,
        input  cache_req_valid, cache_req_addr, cache_req_wdata, cache_req_we, cache_req_is_gpu,
        output cache_req_ready, cache_req_rdata,
        input  busy, cpu_grant_cnt, gpu_grant_cnt
    );
endinterface

// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: weighted round-robin CPU/GPU arbiter for the single cache request port,
// one transaction outstanding, with response watchdog and saturating grant counters.
module cache_req_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int GPU_WEIGHT     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input logic                clk,
    input logic                rst,
    cache_req_arbiter_if.slave io_bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_we;
    logic                  r_is_gpu;
    logic [3:0]            r_streak;
    logic [TW-1:0]         r_tcnt;
    logic [CNT_WIDTH-1:0]  r_cpu_cnt;
    logic [CNT_WIDTH-1:0]  r_gpu_cnt;
    logic                  r_cpu_valid;
    logic                  r_gpu_valid;
    logic [31:0]           r_cpu_rdata;
    logic [31:0]           r_gpu_rdata;
    logic                  r_cpu_err;
    logic                  r_gpu_err;
    logic                  w_idle;
    logic                  w_gnt_gpu;
    logic                  w_gnt_cpu;
    logic                  w_done;
    logic                  w_tmo;
    logic                  w_fin;
    logic [31:0]           w_rdata;

    // A completion arriving on the last allowed cycle beats the watchdog.
    always_comb begin
        w_idle    = r_state == IDLE;
        w_gnt_gpu = io_bus.gpu_req_valid && (!io_bus.cpu_req_valid || r_streak < 4'(GPU_WEIGHT));
        w_gnt_cpu = io_bus.cpu_req_valid && !w_gnt_gpu;
        w_done    = r_state == WAIT_DONE && io_bus.cache_req_ready;
        w_tmo     = (r_state == WAIT_BUSY || r_state == WAIT_DONE) && !w_done
                    && r_tcnt == TW'(TIMEOUT_CYCLES - 1);
        w_fin     = w_done || w_tmo;
        w_rdata   = w_done ? io_bus.cache_req_rdata : 32'd0;
    end

    assign io_bus.cpu_req_ready    = w_idle && w_gnt_cpu;
    assign io_bus.gpu_req_ready    = w_idle && w_gnt_gpu;
    assign io_bus.cache_req_valid  = r_state == ISSUE;
    assign io_bus.cache_req_addr   = r_addr;
    assign io_bus.cache_req_wdata  = r_wdata;
    assign io_bus.cache_req_we     = r_we;
    assign io_bus.cache_req_is_gpu = r_is_gpu;
    assign io_bus.busy             = !w_idle;
    assign io_bus.cpu_grant_cnt    = r_cpu_cnt;
    assign io_bus.gpu_grant_cnt    = r_gpu_cnt;
    assign io_bus.cpu_resp_valid   = r_cpu_valid;
    assign io_bus.cpu_resp_rdata   = r_cpu_rdata;
    assign io_bus.cpu_resp_err     = r_cpu_err;
    assign io_bus.gpu_resp_valid   = r_gpu_valid;
    assign io_bus.gpu_resp_rdata   = r_gpu_rdata;
    assign io_bus.gpu_resp_err     = r_gpu_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_is_gpu    <= 1'b0;
            r_streak    <= '0;
            r_tcnt      <= '0;
            r_cpu_cnt   <= '0;
            r_gpu_cnt   <= '0;
            r_cpu_valid <= 1'b0;
            r_gpu_valid <= 1'b0;
            r_cpu_rdata <= '0;
            r_gpu_rdata <= '0;
            r_cpu_err   <= 1'b0;
            r_gpu_err   <= 1'b0;
        end else begin
            r_cpu_valid <= 1'b0;
            r_gpu_valid <= 1'b0;
            case (r_state)
                IDLE: if (w_gnt_cpu || w_gnt_gpu) begin
                    r_state  <= ISSUE;
                    r_is_gpu <= w_gnt_gpu;
                    r_addr   <= w_gnt_gpu ? io_bus.gpu_req_addr : io_bus.cpu_req_addr;
                    r_wdata  <= w_gnt_gpu ? io_bus.gpu_req_wdata : io_bus.cpu_req_wdata;
                    r_we     <= w_gnt_gpu ? io_bus.gpu_req_we : io_bus.cpu_req_we;
                    r_streak <= w_gnt_gpu && io_bus.cpu_req_valid ? r_streak + 4'd1 : 4'd0;
                    if (w_gnt_gpu)
                        r_gpu_cnt <= r_gpu_cnt + CNT_WIDTH'(r_gpu_cnt != '1);
                    else
                        r_cpu_cnt <= r_cpu_cnt + CNT_WIDTH'(r_cpu_cnt != '1);
                end
                ISSUE: if (io_bus.cache_req_ready) begin
                    r_state <= WAIT_BUSY;
                    r_tcnt  <= '0;
                end
                WAIT_BUSY: begin
                    if (!io_bus.cache_req_ready)
                        r_state <= WAIT_DONE;
                    r_tcnt <= r_tcnt + TW'(1);
                end
                default: r_tcnt <= r_tcnt + TW'(1);
            endcase
            if (w_fin) begin
                r_state <= IDLE;
                if (r_is_gpu) begin
                    r_gpu_valid <= 1'b1;
                    r_gpu_rdata <= w_rdata;
                    r_gpu_err   <= w_tmo;
                end else begin
                    r_cpu_valid <= 1'b1;
                    r_cpu_rdata <= w_rdata;
                    r_cpu_err   <= w_tmo;
                end
            end
        end
    end
endmodule
